// File: rtl/sha_1_pkg.sv
// rtl/sha_1_pkg.sv - shared SHA-1 word/block types and padder constants
package sha_1_pkg;

    typedef logic [31:0] sha_word_t;
    typedef sha_word_t [15:0] sha_block_t;

    typedef enum logic [2:0] {
        FILL,
        PAD,
        ZERO,
        LEN,
        EMIT
    } pad_state_e;

    localparam logic [7:0] PAD_BYTE  = 8'h80;
    localparam int         LEN_POS   = 56;
    localparam int         BLK_BYTES = 64;

endpackage

// File: rtl/sha_1_block_buf.sv
// rtl/sha_1_block_buf.sv - 64-byte block buffer presented as sixteen big-endian words
module sha_1_block_buf
    import sha_1_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        we,
    input  logic [5:0]  pos,
    input  logic [7:0]  data,
    input  logic        len_we,
    input  logic [63:0] len,
    output sha_block_t  words
);

    // Byte 0 of a word is its most significant byte, so the lane offset is (3 - pos%4) * 8.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words <= '0;
        end else if (clr) begin
            words <= '0;
        end else begin
            if (we) begin
                words[pos[5:2]][{~pos[1:0], 3'b000} +: 8] <= data;
            end
            if (len_we) begin
                words[14] <= len[63:32];
                words[15] <= len[31:0];
            end
        end
    end

endmodule

// File: rtl/sha_1_padder.sv
// rtl/sha_1_padder.sv - byte-stream to padded 512-bit SHA-1 block packer
module sha_1_padder
    import sha_1_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    input  logic        in_empty,
    output logic [31:0] blk_data [15:0],
    output logic        blk_valid,
    input  logic        blk_ready,
    output logic        blk_first,
    output logic        blk_last
);

    pad_state_e       state_q, state_d;
    pad_state_e       ret_q, ret_d;
    logic [5:0]       pos_q, pos_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             first_q, first_d;
    logic             lastp_q, lastp_d;
    logic             run_q;

    logic             buf_clr, buf_we, buf_len_we;
    logic [7:0]       buf_byte;
    logic [63:0]      bit_len;
    sha_block_t       words;

    assign bit_len = 64'(len_q) << 3;

    sha_1_block_buf u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (buf_clr),
        .we     (buf_we),
        .pos    (pos_q),
        .data   (buf_byte),
        .len_we (buf_len_we),
        .len    (bit_len),
        .words  (words)
    );

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            blk_data[i] = words[i];
        end
    end

    assign blk_first = first_q;
    assign blk_last  = lastp_q;

    // run_q holds in_ready low while in reset and until the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            ret_q   <= FILL;
            pos_q   <= '0;
            len_q   <= '0;
            first_q <= 1'b1;
            lastp_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            pos_q   <= pos_d;
            len_q   <= len_d;
            first_q <= first_d;
            lastp_q <= lastp_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        pos_d      = pos_q;
        len_d      = len_q;
        first_d    = first_q;
        lastp_d    = lastp_q;
        buf_clr    = 1'b0;
        buf_we     = 1'b0;
        buf_len_we = 1'b0;
        buf_byte   = in_data;
        in_ready   = 1'b0;
        blk_valid  = 1'b0;

        case (state_q)
            FILL: begin
                in_ready = run_q;
                if (run_q && in_valid) begin
                    if (in_empty) begin
                        state_d = PAD;
                    end else begin
                        buf_we = 1'b1;
                        pos_d  = pos_q + 6'd1;
                        len_d  = len_q + LEN_W'(1);
                        if (pos_q == 6'(BLK_BYTES - 1)) begin
                            state_d = EMIT;
                            ret_d   = in_last ? PAD : FILL;
                        end else if (in_last) begin
                            state_d = PAD;
                        end
                    end
                end
            end
            PAD: begin
                buf_we   = 1'b1;
                buf_byte = PAD_BYTE;
                pos_d    = pos_q + 6'd1;
                if (pos_q == 6'(BLK_BYTES - 1)) begin
                    state_d = EMIT;
                    ret_d   = ZERO;
                end else begin
                    state_d = ZERO;
                end
            end
            ZERO: begin
                // A pad that lands past the length field zero-fills to the end, emits, and resumes here at byte 0.
                if (pos_q == 6'(LEN_POS)) begin
                    state_d = LEN;
                end else begin
                    buf_we   = 1'b1;
                    buf_byte = 8'h00;
                    pos_d    = pos_q + 6'd1;
                    if (pos_q == 6'(BLK_BYTES - 1)) begin
                        state_d = EMIT;
                        ret_d   = ZERO;
                    end
                end
            end
            LEN: begin
                buf_len_we = 1'b1;
                lastp_d    = 1'b1;
                state_d    = EMIT;
            end
            EMIT: begin
                blk_valid = 1'b1;
                if (blk_ready) begin
                    buf_clr = 1'b1;
                    pos_d   = '0;
                    first_d = 1'b0;
                    if (lastp_q) begin
                        first_d = 1'b1;
                        lastp_d = 1'b0;
                        len_d   = '0;
                        state_d = FILL;
                    end else begin
                        state_d = ret_q;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

endmodule
